pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V 32 core.
- Successor to the fixed PC+4 adder: it holds the PC register and drives the PC to instruction fetch with a valid/ready handshake.
- Handles stall, branch/jump redirect, misaligned-target trap and halt.
- Sits between the control unit/branch resolution and the instruction memory.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned redirect.
- INC, 4, byte increment per accepted fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard stall; freezes PC.
- halt_i  in  1  enter HALT state (e.g. ecall/ebreak stop).
- redirect_valid_i  in  1  branch taken or jump resolved this cycle.
- redirect_target_i  in  XLEN  redirect destination address.
- fetch_ready_i  in  1  instruction memory accepts the address.
- pc_o  out  XLEN  current fetch address (registered).
- pc_valid_o  out  1  pc_o is a valid fetch request.
- next_pc_o  out  XLEN  pc_o + INC (combinational, for link-register writes).
- misalign_err_o  out  1  one-cycle pulse on a misaligned redirect.
- halted_o  out  1  high while in HALT.

Behaviour:
- Single clock. Reset is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: pc_o=RESET_VECTOR, pc_valid_o=0, misalign_err_o=0, halted_o=0, state=BOOT.
- BOOT state:
  - Lasts exactly one cycle after rst deasserts. pc_valid_o=0.
  - Then moves to RUN. pc_valid_o=1 from the first RUN cycle.
- RUN state, priority per cycle (highest first):
  1. halt_i: go to HALT. pc_o is held. pc_valid_o=0 from the next cycle.
  2. redirect_valid_i with target[1:0]!=0: pc_o<=TRAP_VECTOR. misalign_err_o=1 for the next cycle only. Stays in RUN.
  3. redirect_valid_i, aligned target: pc_o<=redirect_target_i. This happens regardless of stall_i and fetch_ready_i; redirect flushes the stalled address.
  4. stall_i: pc_o is held.
  5. pc_valid_o && fetch_ready_i: pc_o<=pc_o+INC.
  6. Otherwise pc_o is held; the request stays pending. pc_o must not change while pc_valid_o=1 and fetch_ready_i=0, except via rules 1–3.
- HALT state:
  - pc_valid_o=0, halted_o=1. Redirects are ignored.
  - Exit only through rst.
- Arithmetic: next_pc_o = pc_o + INC, modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Latency: one cycle from a redirect/accept edge to the new pc_o.
- rst asserted mid-operation (including in HALT) overrides everything on that edge. BOOT is re-entered.
- halt_i and redirect_valid_i in the same cycle: halt wins, and the redirect is dropped.

Optional Feature:
- Macro: PC_RVC_EN.
- Defined:
  - Adds input is_compressed_i (1 bit).
  - An accepted fetch increments by 2 when is_compressed_i=1, otherwise by INC. next_pc_o follows the same rule.
  - The misalignment check becomes target[0]!=0 (2-byte alignment).
- Undefined:
  - No is_compressed_i port.
  - Fixed INC increment and 4-byte alignment check.

Decomposition:
- Shared package rv32_pkg:
  - XLEN default.
  - State enum (BOOT, RUN, HALT).
  - RESET_VECTOR and TRAP_VECTOR constants.
  - Alignment mask constant.
- Sub-module pc_adder: the parametrised increment adder (XLEN, INC; 2-byte mode under PC_RVC_EN). It generalises the existing PC+4 adder.
- The FSM and PC register stay in pc_gen.

Test Plan:
- Reset and boot: rst=1 for 3 cycles, then 0 → pc_o=0, pc_valid_o=0 in the first cycle after release, then 1. With fetch_ready_i=1, pc_o steps 0,4,8,12.
- Backpressure/stall: pc_o=8 with fetch_ready_i=0 for 3 cycles, then stall_i=1 for 2 cycles → pc_o stays 8 throughout. pc_o=12 one cycle after ready=1 and stall=0.
- Redirect: redirect target 32'h40 while stall_i=1 → pc_o=32'h40 next cycle. Redirect target 32'h42 → pc_o=32'h100 and misalign_err_o=1 for exactly one cycle.
- Wrap-around: redirect to 32'hFFFF_FFFC, accept → pc_o=0, next_pc_o=4, no error.
- Halt: halt_i together with redirect target 32'h80 at pc_o=32'h10 → pc_o stays 32'h10, halted_o=1, pc_valid_o=0. A later redirect is ignored. rst returns pc_o to 0 via BOOT.
- PC_RVC_EN build: from 0, accept with is_compressed_i=1,1,0 → pc_o 2,4,8. Redirect to 32'h6 is accepted without error.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 front-end constants: widths, vectors, PC FSM states.
// Alignment mask narrows to 2-byte when PC_RVC_EN is defined.
package rv32_pkg;
   localparam int XLEN_D = 32;
   localparam logic [31:0] RESET_VEC_D = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC_D = 32'h0000_0100;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

`ifdef PC_RVC_EN
   localparam logic [1:0] ALIGN_MASK = 2'b01;
`else
   localparam logic [1:0] ALIGN_MASK = 2'b11;
`endif
endpackage

// File: rtl/pc_gen_if.sv
// Fetch-address handshake between the PC generator and instruction memory.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] pc_o;
   logic            pc_valid_o;
   logic [XLEN-1:0] next_pc_o;
   logic            fetch_ready_i;

   modport master (
      output pc_o,
      output pc_valid_o,
      output next_pc_o,
      input  fetch_ready_i
   );

   modport slave (
      input  pc_o,
      input  pc_valid_o,
      input  next_pc_o,
      output fetch_ready_i
   );
endinterface

// File: rtl/pc_adder.sv
// Sequential-PC adder; wraps modulo 2^XLEN.
// Under PC_RVC_EN a compressed instruction steps by 2 bytes.
module pc_adder #(
   parameter int XLEN = 32,
   parameter int INC  = 4
) (
   input  logic [XLEN-1:0] pc_i,
`ifdef PC_RVC_EN
   input  logic            compressed_i,
`endif
   output logic [XLEN-1:0] sum_o
);
   localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

`ifdef PC_RVC_EN
   localparam logic [XLEN-1:0] INC_C = XLEN'(2);
   assign sum_o = pc_i + (compressed_i ? INC_C : INC_W);
`else
   assign sum_o = pc_i + INC_W;
`endif
endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT FSM, redirect and trap.
// Build option PC_RVC_EN adds is_compressed_i and 2-byte alignment.
module pc_gen
   import rv32_pkg::*;
#(
   parameter int              XLEN         = XLEN_D,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VEC_D),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VEC_D),
   parameter int              INC          = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_i,
   input  logic            halt_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_target_i,
`ifdef PC_RVC_EN
   input  logic            is_compressed_i,
`endif
   pc_gen_if.master        fetch,
   output logic            misalign_err_o,
   output logic            halted_o
);
   localparam logic [1:0] S_BOOT = BOOT;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_HALT = HALT;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] seq_pc;
   logic            misaligned;

   pc_adder #(
      .XLEN (XLEN),
      .INC  (INC)
   ) u_adder (
      .pc_i         (pc_q),
`ifdef PC_RVC_EN
      .compressed_i (is_compressed_i),
`endif
      .sum_o        (seq_pc)
   );

   assign misaligned = |(redirect_target_i[1:0] & ALIGN_MASK);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_BOOT: state_d = S_RUN;
         S_RUN: begin
            if (halt_i) begin
               state_d = S_HALT;
            end else if (redirect_valid_i && misaligned) begin
               pc_d  = TRAP_VECTOR;
               err_d = 1'b1;
            end else if (redirect_valid_i) begin
               pc_d = redirect_target_i;
            end else if (stall_i) begin
               pc_d = pc_q;
            end else if (fetch.fetch_ready_i) begin
               pc_d = seq_pc;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

   assign fetch.pc_o       = pc_q;
   assign fetch.pc_valid_o = (state_q == S_RUN);
   assign fetch.next_pc_o  = seq_pc;
   assign misalign_err_o   = err_q;
   assign halted_o         = (state_q == S_HALT);
endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen.
// Define PC_RVC_EN to also exercise the compressed-step build.
module tb_pc_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        halt_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_target_i;
   logic        misalign_err_o;
   logic        halted_o;
`ifdef PC_RVC_EN
   logic        is_compressed_i;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pc_gen_if #(.XLEN(32)) fif ();

   pc_gen dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall_i),
      .halt_i            (halt_i),
      .redirect_valid_i  (redirect_valid_i),
      .redirect_target_i (redirect_target_i),
`ifdef PC_RVC_EN
      .is_compressed_i   (is_compressed_i),
`endif
      .fetch             (fif.master),
      .misalign_err_o    (misalign_err_o),
      .halted_o          (halted_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [31:0] exp_pc;
      rst = 1'b1;
      stall_i = 1'b0;
      halt_i = 1'b0;
      redirect_valid_i = 1'b0;
      redirect_target_i = '0;
      fif.fetch_ready_i = 1'b1;
`ifdef PC_RVC_EN
      is_compressed_i = 1'b0;
`endif
      repeat (3) tick();
      n_cmp++;
      if (fif.pc_o !== 32'h0 || fif.pc_valid_o !== 1'b0
          || halted_o !== 1'b0 || misalign_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state pc=%h v=%b h=%b e=%b want 0/0/0/0",
                  fif.pc_o, fif.pc_valid_o, halted_o, misalign_err_o);
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (fif.pc_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL boot_valid got=%b want=0", fif.pc_valid_o);
      end
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h0 || fif.pc_valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL first_run pc=%h v=%b want 0/1",
                  fif.pc_o, fif.pc_valid_o);
      end
      exp_pc = 32'h0;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp_pc = exp_pc + 32'd4;
         n_cmp++;
         if (fif.pc_o !== exp_pc) begin
            n_bad++;
            $display("FAIL step%0d pc=%h want=%h", i, fif.pc_o, exp_pc);
         end
      end
      fif.fetch_ready_i = 1'b0;
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (fif.pc_o !== 32'h8 || fif.pc_valid_o !== 1'b1) begin
            n_bad++;
            $display("FAIL not_ready%0d pc=%h v=%b want 8/1",
                     i, fif.pc_o, fif.pc_valid_o);
         end
      end
      fif.fetch_ready_i = 1'b1;
      stall_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++;
         if (fif.pc_o !== 32'h8) begin
            n_bad++;
            $display("FAIL stall%0d pc=%h want=8", i, fif.pc_o);
         end
      end
      n_cmp++;
      if (fif.next_pc_o !== 32'hC) begin
         n_bad++;
         $display("FAIL next_pc got=%h want=c", fif.next_pc_o);
      end
      stall_i = 1'b0;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'hC) begin
         n_bad++;
         $display("FAIL release pc=%h want=c", fif.pc_o);
      end
   endtask

   task automatic test_redirect();
      logic [31:0] bad_t;
`ifdef PC_RVC_EN
      bad_t = 32'h43;
`else
      bad_t = 32'h42;
`endif
      stall_i = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h40;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h40 || misalign_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL redirect_stall pc=%h e=%b want 40/0",
                  fif.pc_o, misalign_err_o);
      end
      stall_i = 1'b0;
      fif.fetch_ready_i = 1'b0;
      redirect_target_i = bad_t;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h100 || misalign_err_o !== 1'b1) begin
         n_bad++;
         $display("FAIL misalign pc=%h e=%b want 100/1",
                  fif.pc_o, misalign_err_o);
      end
      redirect_valid_i = 1'b0;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h100 || misalign_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL err_pulse pc=%h e=%b want 100/0",
                  fif.pc_o, misalign_err_o);
      end
   endtask

   task automatic test_wrap();
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'hFFFF_FFFC;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'hFFFF_FFFC || fif.next_pc_o !== 32'h0) begin
         n_bad++;
         $display("FAIL wrap_pre pc=%h np=%h want fffffffc/0",
                  fif.pc_o, fif.next_pc_o);
      end
      redirect_valid_i = 1'b0;
      fif.fetch_ready_i = 1'b1;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h0 || fif.next_pc_o !== 32'h4
          || misalign_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap pc=%h np=%h e=%b want 0/4/0",
                  fif.pc_o, fif.next_pc_o, misalign_err_o);
      end
      fif.fetch_ready_i = 1'b0;
   endtask

   task automatic test_halt();
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h10;
      tick();
      halt_i = 1'b1;
      redirect_target_i = 32'h80;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h10 || halted_o !== 1'b1
          || fif.pc_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL halt pc=%h h=%b v=%b want 10/1/0",
                  fif.pc_o, halted_o, fif.pc_valid_o);
      end
      halt_i = 1'b0;
      redirect_target_i = 32'h40;
      fif.fetch_ready_i = 1'b1;
      repeat (2) tick();
      n_cmp++;
      if (fif.pc_o !== 32'h10 || halted_o !== 1'b1) begin
         n_bad++;
         $display("FAIL halt_redirect pc=%h h=%b want 10/1",
                  fif.pc_o, halted_o);
      end
      redirect_valid_i = 1'b0;
      rst = 1'b1;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h0 || halted_o !== 1'b0
          || fif.pc_valid_o !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_reset pc=%h h=%b v=%b want 0/0/0",
                  fif.pc_o, halted_o, fif.pc_valid_o);
      end
      rst = 1'b0;
      fif.fetch_ready_i = 1'b0;
      tick();
      n_cmp++;
      if (fif.pc_o !== 32'h0 || fif.pc_valid_o !== 1'b1) begin
         n_bad++;
         $display("FAIL reboot pc=%h v=%b want 0/1",
                  fif.pc_o, fif.pc_valid_o);
      end
   endtask

`ifdef PC_RVC_EN
   task automatic test_rvc();
      logic [31:0] exp_v [3];
      logic        cmp_v [3];
      exp_v[0] = 32'h2;
      exp_v[1] = 32'h4;
      exp_v[2] = 32'h8;
      cmp_v[0] = 1'b1;
      cmp_v[1] = 1'b1;
      cmp_v[2] = 1'b0;
      fif.fetch_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         is_compressed_i = cmp_v[i];
         tick();
         n_cmp++;
         if (fif.pc_o !== exp_v[i]) begin
            n_bad++;
            $display("FAIL rvc%0d pc=%h want=%h", i, fif.pc_o, exp_v[i]);
         end
      end
      is_compressed_i = 1'b0;
      fif.fetch_ready_i = 1'b0;
      redirect_valid_i = 1'b1;
      redirect_target_i = 32'h6;
      tick();
      redirect_valid_i = 1'b0;
      n_cmp++;
      if (fif.pc_o !== 32'h6 || misalign_err_o !== 1'b0) begin
         n_bad++;
         $display("FAIL rvc_redirect pc=%h e=%b want 6/0",
                  fif.pc_o, misalign_err_o);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_halt();
`ifdef PC_RVC_EN
      test_rvc();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
